// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and program-memory write port of the program loader.
interface program_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    modport master (output byte_in, byte_valid, input byte_ready, mem_write, mem_address, mem_write_data);
    modport slave  (input byte_in, byte_valid, output byte_ready, mem_write, mem_address, mem_write_data);
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a little-endian byte stream into instruction words, writes them to
// program memory and holds the core in reset until the load completes. Define CHECKSUM_EN
// to require a trailing 8-bit sum byte after the data.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    program_loader_if.slave  bus,
    output logic             cpu_reset_n_o,
    output logic             load_done_o,
    output logic             load_error_o
);
    localparam int IW = $clog2(MEMORY_DEPTH) + 1;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;
    state_t        state_q;
    logic [15:0]   count_q, count_d;
    logic [IW-1:0] word_idx_q;
    logic [1:0]    byte_cnt_q;
    logic [31:0]   word_q, word_d;
    logic          mem_write_q, cpu_reset_n_q, load_done_q, load_error_q;
    logic [31:0]   mem_address_q, mem_write_data_q;
    logic          fire, last_word;
`ifdef CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    assign bus.byte_ready     = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA) || (state_q == CHK);
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign cpu_reset_n_o      = cpu_reset_n_q;
    assign load_done_o        = load_done_q;
    assign load_error_o       = load_error_q;
    assign fire               = bus.byte_valid && bus.byte_ready;
    assign count_d            = {bus.byte_in, count_q[7:0]};
    assign last_word          = 16'(word_idx_q) == count_q - 16'd1;

    // New bytes enter at the top so the first byte of a word ends up in [7:0].
    always_comb begin
        word_d = {bus.byte_in, word_q[31:8]};
    end

    // Load sequencer: header, data words, optional checksum, then release the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            count_q          <= '0;
            word_idx_q       <= '0;
            byte_cnt_q       <= '0;
            word_q           <= '0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= BASE_ADDRESS;
            mem_write_data_q <= '0;
            cpu_reset_n_q    <= 1'b0;
            load_done_q      <= 1'b0;
            load_error_q     <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q            <= '0;
`endif
        end else begin
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: if (start_i) begin
                    state_q       <= HDR0;
                    count_q       <= '0;
                    word_idx_q    <= '0;
                    byte_cnt_q    <= '0;
                    cpu_reset_n_q <= 1'b0;
                    load_done_q   <= 1'b0;
                    load_error_q  <= 1'b0;
`ifdef CHECKSUM_EN
                    sum_q         <= '0;
`endif
                end
                HDR0: if (fire) begin
                    count_q[7:0] <= bus.byte_in;
                    state_q      <= HDR1;
                end
                HDR1: if (fire) begin
                    count_q <= count_d;
                    if (count_d == 16'd0 || 32'(count_d) > MEMORY_DEPTH) begin
                        state_q      <= ERR;
                        load_error_q <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (fire) begin
                    word_q     <= word_d;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef CHECKSUM_EN
                    sum_q      <= sum_q + bus.byte_in;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_write_q      <= 1'b1;
                        mem_address_q    <= BASE_ADDRESS + 32'({word_idx_q, 2'b00});
                        mem_write_data_q <= word_d;
                        word_idx_q       <= word_idx_q + 1'b1;
                        if (last_word) begin
`ifdef CHECKSUM_EN
                            state_q <= CHK;
`else
                            state_q       <= DONE;
                            load_done_q   <= 1'b1;
                            cpu_reset_n_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef CHECKSUM_EN
                CHK: if (fire) begin
                    if (bus.byte_in == sum_q) begin
                        state_q       <= DONE;
                        load_done_q   <= 1'b1;
                        cpu_reset_n_q <= 1'b1;
                    end else begin
                        state_q      <= ERR;
                        load_error_q <= 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads with a write scoreboard checked by an independent monitor.
module tb_program_loader;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic cpu_reset_n, load_done, load_error;
    int n_cmp = 0, n_bad = 0;
    int word_k = 0;
    logic [7:0] csum = 8'h0;
    logic [63:0] exp_q[$];

    program_loader_if bus();

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus),
        .cpu_reset_n_o(cpu_reset_n), .load_done_o(load_done), .load_error_o(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && t < 20) begin
            tick();
            t++;
        end
        check("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(b);
        csum = csum + b;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back({32'(word_k) * 32'd4, w});
        word_k++;
        for (int i = 0; i < 4; i++) send_data(w[8*i +: 8]);
    endtask

    task automatic begin_load(input logic [15:0] n);
        start = 1'b1;
        tick();
        start = 1'b0;
        word_k = 0;
        csum = 8'h0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic finish_load();
`ifdef CHECKSUM_EN
        check("cpu_held_before_chk", 32'(cpu_reset_n), 32'd0);
        send_byte(csum);
`endif
        check("load_done", 32'(load_done), 32'd1);
        check("cpu_reset_n_done", 32'(cpu_reset_n), 32'd1);
        check("load_error_done", 32'(load_error), 32'd0);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.mem_write) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.mem_address, bus.mem_write_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.mem_address, bus.mem_write_data} !== e) begin
                    n_bad++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             bus.mem_address, bus.mem_write_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_in = 8'h0;
        bus.byte_valid = 1'b0;
        #1;
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_mem_data", bus.mem_write_data, 32'h0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("idle_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
            check("idle_byte_ready", 32'(bus.byte_ready), 32'd0);
            check("idle_mem_write", 32'(bus.mem_write), 32'd0);
        end

        begin_load(16'd2);
        check("cpu_held_in_data", 32'(cpu_reset_n), 32'd0);
        send_word(32'h20200008);
        check("cpu_held_mid_load", 32'(cpu_reset_n), 32'd0);
        send_word(32'h20210005);
        finish_load();

        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_clear", 32'(load_done), 32'd0);
        check("restart_cpu_held", 32'(cpu_reset_n), 32'd0);
        word_k = 0;
        csum = 8'h0;
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back({32'h0, 32'h20200008});
        word_k = 1;
        send_data(8'h08);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        send_data(8'h00);
        send_data(8'h20);
        send_data(8'h20);
        check("start_ignored_no_done", 32'(load_done), 32'd0);
        send_word(32'h20210005);
        finish_load();

        begin_load(16'd33);
        check("n33_error", 32'(load_error), 32'd1);
        check("n33_cpu_held", 32'(cpu_reset_n), 32'd0);
        check("n33_ready_low", 32'(bus.byte_ready), 32'd0);
        check("n33_done_low", 32'(load_done), 32'd0);
        begin_load(16'd0);
        check("n0_error", 32'(load_error), 32'd1);
        begin_load(16'd32);
        check("n32_error_clear", 32'(load_error), 32'd0);
        for (int k = 0; k < 32; k++) send_word({8'h33, 8'h22, 8'h11, 8'(k)});
        finish_load();

`ifdef CHECKSUM_EN
        begin_load(16'd1);
        send_word(32'hDDCCBBAA);
        send_byte(8'h0E);
        check("chk_good_done", 32'(load_done), 32'd1);
        check("chk_good_cpu", 32'(cpu_reset_n), 32'd1);
        begin_load(16'd1);
        send_word(32'hDDCCBBAA);
        send_byte(8'h0F);
        check("chk_bad_error", 32'(load_error), 32'd1);
        check("chk_bad_done", 32'(load_done), 32'd0);
        check("chk_bad_cpu", 32'(cpu_reset_n), 32'd0);
`endif

        begin_load(16'd2);
        send_word(32'h20200008);
        send_data(8'h08);
        send_data(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_address", bus.mem_address, 32'h0);
        check("async_rst_mem_data", bus.mem_write_data, 32'h0);
        check("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("async_rst_ready", 32'(bus.byte_ready), 32'd0);
        check("async_rst_cpu", 32'(cpu_reset_n), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus.byte_in = 8'hFF;
        bus.byte_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.byte_valid = 1'b0;
        check("start_byte_same_cycle_hdr0", 32'(bus.byte_ready), 32'd1);
        word_k = 0;
        csum = 8'h0;
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h12345678);
        finish_load();

        repeat (3) tick();
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
